// File: rtl/relu2_stage_if.sv
// Bus bundle for relu2_stage: the upstream read port, the downstream write port and the
// start/busy/done handshake. The slave modport is the stage itself; the master modport is
// its environment, which holds both buffers and the controller.
interface relu2_stage_if;
   logic        start;
   logic [15:0] read_addr;
   logic [31:0] data_in;
   logic [15:0] write_addr;
   logic [31:0] data_out;
   logic        write_enable;
   logic        busy;
   logic        done;

   modport slave (
      input  start,
      input  data_in,
      output read_addr,
      output write_addr,
      output data_out,
      output write_enable,
      output busy,
      output done
   );

   modport master (
      output start,
      output data_in,
      input  read_addr,
      input  write_addr,
      input  data_out,
      input  write_enable,
      input  busy,
      input  done
   );
endinterface

// File: rtl/relu2_stage.sv
// Activation stage: walks N entries of the upstream buffer one per cycle and applies ReLU,
// an arithmetic right shift and an upper clamp. Each result is written in index order to the
// downstream buffer, and done is pulsed once the last write has been presented.
module relu2_stage #(
   parameter int unsigned N       = 64,
   parameter int unsigned SHIFT   = 0,
   parameter logic [31:0] SAT_MAX = 32'h7FFF_FFFF
) (
   input logic          clk,
   input logic          reset,
   relu2_stage_if.slave bus
);

   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e          state_q;
   logic [IdxW-1:0] idx_q;
   logic [15:0]     write_addr_q;
   logic [31:0]     data_out_q;
   logic            write_enable_q;
   logic            done_q;

   logic [31:0]     shifted;
   logic [31:0]     f_res;

   // ReLU, then arithmetic shift, then upper clamp. A non-negative shifted value compares
   // correctly against SAT_MAX as unsigned, because SAT_MAX is non-negative too.
   always_comb begin
      shifted = 32'($signed(bus.data_in) >>> SHIFT);
      f_res   = shifted;
      if (bus.data_in[31]) begin
         f_res = '0;
      end else if (shifted > SAT_MAX) begin
         f_res = SAT_MAX;
      end
   end

   // Sequencer and registered write-port outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         write_addr_q   <= '0;
         data_out_q     <= '0;
         write_enable_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q         <= 1'b0;
               write_enable_q <= 1'b0;
               if (bus.start) begin
                  state_q <= StRun;
                  idx_q   <= '0;
               end
            end
            StRun: begin
               write_addr_q   <= 16'(idx_q);
               data_out_q     <= f_res;
               write_enable_q <= 1'b1;
               if (idx_q == IdxLast) begin
                  // idx is held; the last write is still on the bus during the drain cycle.
                  state_q <= StDrain;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            StDrain: begin
               write_enable_q <= 1'b0;
               done_q         <= 1'b1;
               state_q        <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Read address is combinational so data_in returns in the same cycle; busy decodes state.
   always_comb begin
      bus.read_addr    = (state_q == StRun) ? 16'(idx_q) : 16'd0;
      bus.busy         = (state_q != StIdle);
      bus.write_addr   = write_addr_q;
      bus.data_out     = data_out_q;
      bus.write_enable = write_enable_q;
      bus.done         = done_q;
   end

endmodule

// File: tb/tb_relu2_stage.sv
// Bench for relu2_stage: one instance with the default shape (N=64, SHIFT=0, full clamp) and
// one small instance (N=8, SHIFT=4, SAT_MAX=127). Downstream commits are logged with the edge
// number they land on and compared against a plain-arithmetic model of the activation.
`timescale 1ns/1ps
module tb_relu2_stage;

   localparam int unsigned N0 = 64;
   localparam int unsigned N1 = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   relu2_stage_if b0 ();
   relu2_stage_if b1 ();

   relu2_stage #(.N(N0), .SHIFT(0), .SAT_MAX(32'h7FFF_FFFF)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b0)
   );

   relu2_stage #(.N(N1), .SHIFT(4), .SAT_MAX(32'd127)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   logic [31:0] mem0 [N0];
   logic [31:0] mem1 [N1];
   assign b0.data_in = mem0[b0.read_addr[5:0]];
   assign b1.data_in = mem1[b1.read_addr[2:0]];

   typedef struct {
      int unsigned at;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wq0 [$];
   wr_t         wq1 [$];
   int unsigned cyc   = 0;
   int unsigned dcnt0 = 0;
   int unsigned dcnt1 = 0;
   int          n_vec = 0;
   int          n_err = 0;

   // Downstream buffers: commit on any edge where write_enable is high; cyc numbers edges.
   always @(posedge clk) begin
      if (b0.write_enable === 1'b1) wq0.push_back('{cyc, b0.write_addr, b0.data_out});
      if (b1.write_enable === 1'b1) wq1.push_back('{cyc, b1.write_addr, b1.data_out});
      if (b0.done === 1'b1) dcnt0 <= dcnt0 + 1;
      if (b1.done === 1'b1) dcnt1 <= dcnt1 + 1;
      cyc <= cyc + 1;
   end

   // Reference: negative -> 0, else divide by 2**sh, then clamp to sat.
   function automatic logic [31:0] ref_f(input logic [31:0] x, input int unsigned sh,
                                         input logic [31:0] sat);
      longint v;
      if ($signed(x) < 0) return 32'd0;
      v = longint'(x) / (longint'(1) << sh);
      if (v > longint'(sat)) return sat;
      return 32'(v);
   endfunction

   // Stimulus helpers: s is the number of the edge that samples start.
   task automatic launch0(output int unsigned s);
      @(posedge clk); #1;
      b0.start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      b0.start = 1'b0;
   endtask

   task automatic launch1(output int unsigned s);
      @(posedge clk); #1;
      b1.start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      b1.start = 1'b0;
   endtask

   // Returns cyc at the negedge inside the done cycle, or 0 on timeout.
   task automatic wait_done0(output int unsigned at);
      bit seen = 0;
      at = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (b0.done === 1'b1) begin
            seen = 1;
            at = cyc;
         end
      end
   endtask

   task automatic wait_done1(output int unsigned at);
      bit seen = 0;
      at = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (b1.done === 1'b1) begin
            seen = 1;
            at = cyc;
         end
      end
   endtask

   task automatic wait_raddr0(input logic [15:0] a, output bit ok);
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (b0.read_addr === a && b0.busy === 1'b1) ok = 1;
      end
   endtask

   task automatic test_reset();
      #2;
      n_vec++;
      if ({b0.read_addr, b0.write_addr, b0.data_out, b0.write_enable, b0.busy, b0.done} !== '0)
      begin
         n_err++;
         $display("FAIL reset0: ra=%h wa=%h do=%h we=%b busy=%b done=%b, need all 0",
                  b0.read_addr, b0.write_addr, b0.data_out, b0.write_enable, b0.busy, b0.done);
      end
      n_vec++;
      if ({b1.read_addr, b1.write_addr, b1.data_out, b1.write_enable, b1.busy, b1.done} !== '0)
      begin
         n_err++;
         $display("FAIL reset1: ra=%h wa=%h do=%h we=%b busy=%b done=%b, need all 0",
                  b1.read_addr, b1.write_addr, b1.data_out, b1.write_enable, b1.busy, b1.done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int unsigned s, at, d0;
      logic [31:0] exp_d;
      for (int i = 0; i < int'(N0); i++) mem0[i] = 32'(i - 32);
      wq0.delete();
      d0 = dcnt0;
      launch0(s);
      @(negedge clk);
      n_vec++;
      if (b0.busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy: busy=%b during run, need 1", b0.busy);
      end
      wait_done0(at);
      n_vec++;
      if (at !== s + N0 + 2) begin
         n_err++;
         $display("FAIL basic_done_time: done at %0d, need %0d", at, s + N0 + 2);
      end
      n_vec++;
      if (b0.busy !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy_done: busy=%b in done cycle, need 0", b0.busy);
      end
      @(negedge clk);
      n_vec++;
      if (b0.done !== 1'b0 || dcnt0 - d0 !== 1) begin
         n_err++;
         $display("FAIL basic_done_pulse: done=%b count=%0d, need 0 and 1", b0.done, dcnt0 - d0);
      end
      n_vec++;
      if (wq0.size() !== N0) begin
         n_err++;
         $display("FAIL basic_count: %0d writes, need %0d", wq0.size(), N0);
      end
      for (int i = 0; i < int'(N0) && i < wq0.size(); i++) begin
         exp_d = (i < 32) ? 32'd0 : 32'(i - 32);
         n_vec++;
         if (wq0[i].at !== s + 32'(i) + 2 || wq0[i].addr !== 16'(i) || wq0[i].data !== exp_d) begin
            n_err++;
            $display("FAIL basic_wr[%0d]: edge %0d addr %0d data %h, need %0d %0d %h", i,
                     wq0[i].at, wq0[i].addr, wq0[i].data, s + 32'(i) + 2, i, exp_d);
         end
      end
   endtask

   task automatic test_extremes();
      logic [31:0] xin  [4];
      logic [31:0] xout [4];
      logic [31:0] exp_d;
      int unsigned s, at;
      xin  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
      xout = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
      for (int i = 0; i < int'(N0); i++) mem0[i] = (i < 4) ? xin[i] : $urandom;
      wq0.delete();
      launch0(s);
      wait_done0(at);
      n_vec++;
      if (at !== s + N0 + 2 || wq0.size() !== N0) begin
         n_err++;
         $display("FAIL ext_run: done at %0d with %0d writes, need %0d and %0d",
                  at, wq0.size(), s + N0 + 2, N0);
      end
      for (int i = 0; i < int'(N0) && i < wq0.size(); i++) begin
         exp_d = (i < 4) ? xout[i] : ref_f(mem0[i], 0, 32'h7FFF_FFFF);
         n_vec++;
         if (wq0[i].addr !== 16'(i) || wq0[i].data !== exp_d) begin
            n_err++;
            $display("FAIL ext_wr[%0d]: addr %0d data %h (in %h), need %0d %h", i,
                     wq0[i].addr, wq0[i].data, mem0[i], i, exp_d);
         end
      end
   endtask

   task automatic test_shift_clamp();
      logic [31:0] xin  [3];
      logic [31:0] xout [3];
      logic [31:0] exp_d;
      int unsigned s, at;
      xin  = '{32'h0000_1000, 32'h0000_0050, 32'h0000_07F0};
      xout = '{32'd127, 32'd5, 32'd127};
      for (int i = 0; i < int'(N1); i++) mem1[i] = (i < 3) ? xin[i] : $urandom_range(0, 4095);
      wq1.delete();
      launch1(s);
      wait_done1(at);
      n_vec++;
      if (at !== s + N1 + 2 || wq1.size() !== N1) begin
         n_err++;
         $display("FAIL shc_run: done at %0d with %0d writes, need %0d and %0d",
                  at, wq1.size(), s + N1 + 2, N1);
      end
      for (int i = 0; i < int'(N1) && i < wq1.size(); i++) begin
         exp_d = (i < 3) ? xout[i] : ref_f(mem1[i], 4, 32'd127);
         n_vec++;
         if (wq1[i].at !== s + 32'(i) + 2 || wq1[i].addr !== 16'(i) || wq1[i].data !== exp_d) begin
            n_err++;
            $display("FAIL shc_wr[%0d]: edge %0d addr %0d data %h (in %h), need %0d %0d %h", i,
                     wq1[i].at, wq1[i].addr, wq1[i].data, mem1[i], s + 32'(i) + 2, i, exp_d);
         end
      end
   endtask

   task automatic test_random();
      int unsigned s, at;
      logic [31:0] exp_d;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < int'(N0); i++) mem0[i] = $urandom;
         for (int i = 0; i < int'(N1); i++) begin
            mem1[i] = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 3000)) - 32'd500;
         end
         wq0.delete();
         wq1.delete();
         launch0(s);
         wait_done0(at);
         for (int i = 0; i < int'(N0); i++) begin
            exp_d = ref_f(mem0[i], 0, 32'h7FFF_FFFF);
            n_vec++;
            if (i >= wq0.size() || wq0[i].addr !== 16'(i) || wq0[i].data !== exp_d) begin
               n_err++;
               $display("FAIL rnd0[%0d.%0d]: got %0d writes, in %h, need addr %0d data %h",
                        r, i, wq0.size(), mem0[i], i, exp_d);
            end
         end
         launch1(s);
         wait_done1(at);
         for (int i = 0; i < int'(N1); i++) begin
            exp_d = ref_f(mem1[i], 4, 32'd127);
            n_vec++;
            if (i >= wq1.size() || wq1[i].addr !== 16'(i) || wq1[i].data !== exp_d) begin
               n_err++;
               $display("FAIL rnd1[%0d.%0d]: got %0d writes, in %h, need addr %0d data %h",
                        r, i, wq1.size(), mem1[i], i, exp_d);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      int unsigned s, at, d0;
      bit ok;
      for (int i = 0; i < int'(N0); i++) mem0[i] = $urandom;
      wq0.delete();
      d0 = dcnt0;
      launch0(s);
      wait_raddr0(16'd20, ok);
      b0.start = 1'b1;
      @(posedge clk); #1;
      b0.start = 1'b0;
      wait_done0(at);
      n_vec++;
      if (!ok || at !== s + N0 + 2) begin
         n_err++;
         $display("FAIL ign_done: reached idx20=%0d done at %0d, need 1 and %0d",
                  ok, at, s + N0 + 2);
      end
      repeat (10) @(negedge clk);
      n_vec++;
      if (wq0.size() !== N0 || dcnt0 - d0 !== 1 || b0.busy !== 1'b0) begin
         n_err++;
         $display("FAIL ign_count: %0d writes %0d dones busy=%b, need %0d 1 0",
                  wq0.size(), dcnt0 - d0, b0.busy, N0);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned s, at1, at2, d0, exp_at;
      for (int i = 0; i < int'(N0); i++) mem0[i] = $urandom;
      wq0.delete();
      d0 = dcnt0;
      @(posedge clk); #1;
      b0.start = 1'b1;
      s = cyc;
      wait_done0(at1);
      repeat (5) @(negedge clk);
      b0.start = 1'b0;
      wait_done0(at2);
      n_vec++;
      if (at1 !== s + N0 + 2 || at2 !== s + 2 * N0 + 4) begin
         n_err++;
         $display("FAIL b2b_done: done at %0d,%0d, need %0d,%0d",
                  at1, at2, s + N0 + 2, s + 2 * N0 + 4);
      end
      n_vec++;
      if (wq0.size() <= N0 || wq0[N0].at !== at1 + 2 || wq0[N0].addr !== 16'd0) begin
         n_err++;
         $display("FAIL b2b_first: %0d writes, run2 first write missing or late, need edge %0d",
                  wq0.size(), at1 + 2);
      end
      for (int i = 0; i < int'(2 * N0) && i < wq0.size(); i++) begin
         exp_at = s + 32'(i) + ((i < int'(N0)) ? 2 : 4);
         n_vec++;
         if (wq0[i].at !== exp_at || wq0[i].addr !== 16'(i % int'(N0)) ||
             wq0[i].data !== ref_f(mem0[i % int'(N0)], 0, 32'h7FFF_FFFF)) begin
            n_err++;
            $display("FAIL b2b_wr[%0d]: edge %0d addr %0d data %h, need edge %0d addr %0d", i,
                     wq0[i].at, wq0[i].addr, wq0[i].data, exp_at, i % int'(N0));
         end
      end
      repeat (N0 + 5) @(negedge clk);
      n_vec++;
      if (wq0.size() !== 2 * N0 || dcnt0 - d0 !== 2) begin
         n_err++;
         $display("FAIL b2b_stop: %0d writes %0d dones, need %0d and 2",
                  wq0.size(), dcnt0 - d0, 2 * N0);
      end
   endtask

   task automatic test_reset_midrun();
      int unsigned s, at, d0, n_before;
      bit ok;
      for (int i = 0; i < int'(N0); i++) mem0[i] = $urandom;
      wq0.delete();
      launch0(s);
      wait_raddr0(16'd10, ok);
      #1;
      reset = 1'b1;
      #1;
      n_vec++;
      if (!ok || {b0.read_addr, b0.write_addr, b0.data_out, b0.write_enable, b0.busy,
                  b0.done} !== '0) begin
         n_err++;
         $display("FAIL rst_async: idx10=%0d ra=%h wa=%h do=%h we=%b busy=%b, need 1 and all 0",
                  ok, b0.read_addr, b0.write_addr, b0.data_out, b0.write_enable, b0.busy);
      end
      n_before = wq0.size();
      d0 = dcnt0;
      @(negedge clk);
      reset = 1'b0;
      repeat (N0 + 10) @(negedge clk);
      n_vec++;
      if (wq0.size() !== n_before || dcnt0 !== d0 || b0.busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_abandon: writes %0d->%0d dones %0d->%0d busy=%b, need no change, 0",
                  n_before, wq0.size(), d0, dcnt0, b0.busy);
      end
      wq0.delete();
      launch0(s);
      wait_done0(at);
      n_vec++;
      if (at !== s + N0 + 2 || wq0.size() !== N0) begin
         n_err++;
         $display("FAIL rst_rerun: done at %0d with %0d writes, need %0d and %0d",
                  at, wq0.size(), s + N0 + 2, N0);
      end
      for (int i = 0; i < int'(N0) && i < wq0.size(); i++) begin
         n_vec++;
         if (wq0[i].addr !== 16'(i) || wq0[i].data !== ref_f(mem0[i], 0, 32'h7FFF_FFFF)) begin
            n_err++;
            $display("FAIL rst_wr[%0d]: addr %0d data %h, need addr %0d in %h", i,
                     wq0[i].addr, wq0[i].data, i, mem0[i]);
         end
      end
   endtask

   initial begin
      b0.start = 1'b0;
      b1.start = 1'b0;
      for (int i = 0; i < int'(N0); i++) mem0[i] = '0;
      for (int i = 0; i < int'(N1); i++) mem1[i] = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_shift_clamp();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
